// File: rtl/out_channel_reader.sv
// Out-channel reader: NOut-deep circular FIFO from the program's out port to a host valid/ready port.
// A write shows on readData straight after its edge; outFull stalls the program and a write while full is dropped.
module out_channel_reader #(
  parameter  int MemoryElementWidth = 12,
  parameter  int NOut               = 200,
  parameter  int CountWidth         = 16,
  localparam int CntW               = $clog2(NOut + 1),
  localparam int PtrW               = (NOut > 1) ? $clog2(NOut) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          outValid,
  input  logic [MemoryElementWidth-1:0] outData,
  output logic                          outFull,
  input  logic                          finished,
  output logic                          readValid,
  output logic [MemoryElementWidth-1:0] readData,
  input  logic                          readReady,
  output logic [CntW-1:0]               count,
  output logic [CountWidth-1:0]         delivered,
  output logic                          overflow,
  output logic                          drained
);

  logic [MemoryElementWidth-1:0] r_mem [NOut];
  logic [PtrW-1:0]               r_wp;
  logic [PtrW-1:0]               r_rp;
  logic [CntW-1:0]               r_count;
  logic [CountWidth-1:0]         r_delivered;
  logic                          r_overflow;
  logic                          r_finish_seen;

  logic                          w_full;
  logic                          w_empty;
  logic                          w_wr;
  logic                          w_rd;
  logic                          w_drop;
  logic [PtrW-1:0]               w_wp_nxt;
  logic [PtrW-1:0]               w_rp_nxt;

  assign w_full  = (r_count == CntW'(NOut));
  assign w_empty = (r_count == '0);
  // Qualification uses the registered count only, so a same-cycle read never rescues a write while full.
  assign w_wr    = outValid && !w_full;
  assign w_drop  = outValid && w_full;
  assign w_rd    = readReady && !w_empty;

  assign w_wp_nxt = (r_wp == PtrW'(NOut - 1)) ? '0 : r_wp + PtrW'(1);
  assign w_rp_nxt = (r_rp == PtrW'(NOut - 1)) ? '0 : r_rp + PtrW'(1);

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wp] <= outData;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wp          <= '0;
      r_rp          <= '0;
      r_count       <= '0;
      r_delivered   <= '0;
      r_overflow    <= 1'b0;
      r_finish_seen <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wp <= w_wp_nxt;
      end
      if (w_rd) begin
        r_rp        <= w_rp_nxt;
        r_delivered <= r_delivered + CountWidth'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (finished) begin
        r_finish_seen <= 1'b1;
      end
    end
  end

  assign readValid = !w_empty;
  assign readData  = r_mem[r_rp];
  assign outFull   = w_full;
  assign count     = r_count;
  assign delivered = r_delivered;
  assign overflow  = r_overflow;
  assign drained   = r_finish_seen && w_empty;

endmodule

// File: tb/tb_out_channel_reader.sv
// Bench for out_channel_reader: a reference count and an expected-word queue filled as writes are driven.
module tb_out_channel_reader;

  localparam int W    = 12;
  localparam int NOUT = 200;
  localparam int CW   = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          outValid;
  logic [W-1:0]  outData;
  logic          outFull;
  logic          finished;
  logic          readValid;
  logic [W-1:0]  readData;
  logic          readReady;
  logic [7:0]    count;
  logic [CW-1:0] delivered;
  logic          overflow;
  logic          drained;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W-1:0]  sb [$];
  int            m_count = 0;
  logic [CW-1:0] exp_deliv = '0;

  out_channel_reader #(.MemoryElementWidth(W), .NOut(NOUT), .CountWidth(CW)) dut (
    .clock(clock), .reset(reset), .outValid(outValid), .outData(outData),
    .outFull(outFull), .finished(finished), .readValid(readValid),
    .readData(readData), .readReady(readReady), .count(count),
    .delivered(delivered), .overflow(overflow), .drained(drained)
  );

  always #5 clock = ~clock;

  // One clock: drive at the negedge, update the reference model, return at the next negedge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic rr, input logic fin,
                       output logic got, output logic [W-1:0] dat);
    logic acc;
    outValid = v; outData = d; readReady = rr; finished = fin;
    #1;
    acc = v && (m_count < NOUT);
    got = rr && (m_count != 0);
    dat = readData;
    if (acc) sb.push_back(d);
    if (acc && !got) m_count++;
    if (got && !acc) m_count--;
    if (got) exp_deliv++;
    @(posedge clock);
    @(negedge clock);
    outValid = 1'b0; readReady = 1'b0; finished = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; outValid = 0; outData = '0; readReady = 0; finished = 0;
    #2;
    n_tests++;
    if ({readValid, outFull, count, delivered, overflow, drained} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rv=%0b full=%0b cnt=%0d del=%0d ovf=%0b drn=%0b required all 0",
               readValid, outFull, count, delivered, overflow, drained);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic_order();
    logic got; logic [W-1:0] dat; logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, W'(i), 1'b0, 1'b0, got, dat);
      n_tests++;
      if (count !== 8'(i + 1)) begin n_fail++; $display("FAIL basic_count_up: got %0d required %0d", count, i + 1); end
      if (i == 0) begin
        n_tests++;
        if (readValid !== 1'b1 || readData !== W'(0)) begin
          n_fail++; $display("FAIL write_latency: got rv=%0b data=%0d required rv=1 data=0", readValid, readData);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, got, dat);
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if (!got || dat !== e) begin n_fail++; $display("FAIL basic_data: got %0d required %0d", dat, e); end
      n_tests++;
      if (count !== 8'(2 - i)) begin n_fail++; $display("FAIL basic_count_down: got %0d required %0d", count, 2 - i); end
    end
    n_tests++;
    if (delivered !== exp_deliv || exp_deliv !== CW'(3)) begin
      n_fail++; $display("FAIL basic_delivered: got %0d required 3", delivered);
    end
    n_tests++;
    if (readValid !== 1'b0) begin n_fail++; $display("FAIL basic_rv_low: got %0b required 0", readValid); end
  endtask

  task automatic test_fill_overflow();
    logic got; logic [W-1:0] dat; logic [W-1:0] e; int mism = 0;
    for (int i = 0; i < NOUT; i++) begin
      n_tests++;
      if (outFull !== 1'b0) begin n_fail++; $display("FAIL fill_early_full: got 1 required 0 at word %0d", i); end
      cycle(1'b1, W'(i), 1'b0, 1'b0, got, dat);
    end
    n_tests++;
    if (outFull !== 1'b1 || count !== 8'(NOUT)) begin
      n_fail++; $display("FAIL fill_full: got full=%0b cnt=%0d required full=1 cnt=200", outFull, count);
    end
    cycle(1'b1, W'(555), 1'b0, 1'b0, got, dat);
    n_tests++;
    if (overflow !== 1'b1 || count !== 8'(NOUT)) begin
      n_fail++; $display("FAIL overflow_set: got ovf=%0b cnt=%0d required ovf=1 cnt=200", overflow, count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, got, dat);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (!got || dat !== e || e !== W'(0)) begin n_fail++; $display("FAIL overflow_first_read: got %0d required 0", dat); end
    n_tests++;
    if (outFull !== 1'b0) begin n_fail++; $display("FAIL full_fall: got %0b required 0", outFull); end
    for (int i = 0; i < NOUT + 5 && m_count != 0; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, got, dat);
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      if (got && dat !== e) mism++;
    end
    n_tests++;
    if (mism != 0 || readValid !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL fill_drain: got %0d mismatches rv=%0b left=%0d required 0 0 0", mism, readValid, sb.size());
    end
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %0b required 1", overflow); end
  endtask

  task automatic test_wrap();
    logic got; logic [W-1:0] dat; logic [W-1:0] e; int mism = 0; int big = 0;
    for (int i = 0; i < 150; i++) cycle(1'b1, W'(i + 1000), 1'b0, 1'b0, got, dat);
    for (int i = 0; i < 150; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, got, dat);
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      if (!got || dat !== e) mism++;
    end
    for (int i = 100; i <= 200; i++) begin
      cycle(i <= 199, W'(i), 1'b1, 1'b0, got, dat);
      if (got) begin
        e = (sb.size() != 0) ? sb.pop_front() : 'x;
        if (dat !== e) mism++;
      end
      if (count > 8'd2) big++;
    end
    n_tests++;
    if (mism != 0 || exp_deliv !== delivered) begin
      n_fail++; $display("FAIL wrap_order: got %0d mismatches del=%0d required 0 del=%0d", mism, delivered, exp_deliv);
    end
    n_tests++;
    if (big != 0 || count !== 8'd0) begin
      n_fail++; $display("FAIL wrap_count: got %0d cycles above 2 cnt=%0d required 0 cnt=0", big, count);
    end
  endtask

  task automatic test_back_to_back();
    logic got; logic [W-1:0] dat; logic [W-1:0] e; logic [CW-1:0] d0; int mism = 0; int bad = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(300 + i), 1'b0, 1'b0, got, dat);
    d0 = delivered;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, W'(400 + i), 1'b1, 1'b0, got, dat);
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      if (!got || dat !== e) mism++;
      if (count !== 8'd5) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL simul_count: got %0d cycles with cnt!=5 required 0", bad); end
    n_tests++;
    if (delivered - d0 !== CW'(20)) begin n_fail++; $display("FAIL simul_delivered: got +%0d required +20", delivered - d0); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, got, dat);
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      if (!got || dat !== e) mism++;
    end
    n_tests++;
    if (mism != 0 || readValid !== 1'b0) begin
      n_fail++; $display("FAIL simul_order: got %0d mismatches rv=%0b required 0 rv=0", mism, readValid);
    end
  endtask

  task automatic test_drain();
    logic got; logic [W-1:0] dat; logic [W-1:0] e;
    cycle(1'b1, W'(7), 1'b0, 1'b0, got, dat);
    cycle(1'b1, W'(8), 1'b0, 1'b0, got, dat);
    cycle(1'b0, '0, 1'b0, 1'b1, got, dat);
    n_tests++;
    if (drained !== 1'b0) begin n_fail++; $display("FAIL drain_cnt2: got %0b required 0", drained); end
    cycle(1'b0, '0, 1'b1, 1'b0, got, dat);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (drained !== 1'b0 || dat !== e) begin n_fail++; $display("FAIL drain_cnt1: got drn=%0b data=%0d required drn=0 data=%0d", drained, dat, e); end
    cycle(1'b0, '0, 1'b1, 1'b0, got, dat);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (drained !== 1'b1 || dat !== e) begin n_fail++; $display("FAIL drain_set: got drn=%0b data=%0d required drn=1 data=%0d", drained, dat, e); end
    cycle(1'b1, W'(9), 1'b0, 1'b0, got, dat);
    n_tests++;
    if (drained !== 1'b0) begin n_fail++; $display("FAIL drain_rewrite: got %0b required 0", drained); end
    cycle(1'b0, '0, 1'b1, 1'b0, got, dat);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (drained !== 1'b1 || dat !== e || e !== W'(9)) begin n_fail++; $display("FAIL drain_again: got drn=%0b data=%0d required drn=1 data=9", drained, dat); end
  endtask

  task automatic test_reset_mid();
    logic got; logic [W-1:0] dat; logic [W-1:0] e;
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(60 + i), 1'b0, 1'b0, got, dat);
    n_tests++;
    if (count !== 8'd4 || overflow !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got cnt=%0d ovf=%0b required cnt=4 ovf=1", count, overflow); end
    #2;
    reset = 1'b0;
    #1;
    sb.delete(); m_count = 0; exp_deliv = '0;
    n_tests++;
    if ({readValid, outFull, count, delivered, overflow, drained} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got rv=%0b full=%0b cnt=%0d del=%0d ovf=%0b drn=%0b required all 0",
               readValid, outFull, count, delivered, overflow, drained);
    end
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b1, W'(42), 1'b0, 1'b0, got, dat);
    cycle(1'b0, '0, 1'b1, 1'b0, got, dat);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (!got || dat !== e || e !== W'(42) || delivered !== CW'(1)) begin
      n_fail++; $display("FAIL post_reset: got data=%0d del=%0d required data=42 del=1", dat, delivered);
    end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_fill_overflow();
    test_wrap();
    test_back_to_back();
    test_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
